// File: rtl/mat_mult_seq.sv
// Folded NxN matrix multiplier: C = A*B or C = C_prev + A*B, LANES shared MACs.
// Operand and result sides each use a valid/ready handshake; arithmetic wraps mod 2^BITS.
module mat_mult_seq #(
  parameter int BITS  = 8,
  parameter int N     = 4,
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  acc_en,
  input  logic [N*N*BITS-1:0]   A,
  input  logic [N*N*BITS-1:0]   B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*N*BITS-1:0]   C,
  output logic                  busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(N*N);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]            state;
  logic [N*N*BITS-1:0]   a_reg, b_reg, c_reg;
  logic                  acc_mode;
  logic [CW-1:0]         i, j, k;
  logic [BITS-1:0]       lane_sum, psum, acc, elem_sum, c_old;
  logic                  p_vld, p_first, p_last;
  logic [IW-1:0]         p_idx;
  logic                  last_k, last_j, last_i;
  int unsigned           ri, rj, rk;

  assign last_k = (k == CW'(N - LANES));
  assign last_j = (j == CW'(N - 1));
  assign last_i = (i == CW'(N - 1));

  // Lane l covers inner index k+l of element (i,j); lane products summed mod 2^BITS.
  always_comb begin
    ri       = 32'(i);
    rj       = 32'(j);
    rk       = 0;
    lane_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      rk       = 32'(k) + l;
      lane_sum = lane_sum + a_reg[BITS*(ri*N + rk) +: BITS] * b_reg[BITS*(rk*N + rj) +: BITS];
    end
  end

  assign elem_sum = (p_first ? '0 : acc) + psum;
  assign c_old    = c_reg[BITS*32'(p_idx) +: BITS];

  // Two-stage datapath: lane sums are registered, then folded into the element
  // accumulator; the FLUSH cycle drains the final element before DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= '0;
      acc_mode <= 1'b0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      psum     <= '0;
      acc      <= '0;
      p_vld    <= 1'b0;
      p_first  <= 1'b0;
      p_last   <= 1'b0;
      p_idx    <= '0;
    end else begin
      p_vld <= 1'b0;
      if (p_vld) begin
        if (p_last) c_reg[BITS*32'(p_idx) +: BITS] <= elem_sum + (acc_mode ? c_old : '0);
        else        acc <= elem_sum;
      end
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            acc_mode <= acc_en;
            if (!acc_en) c_reg <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            state    <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          p_vld   <= 1'b1;
          psum    <= lane_sum;
          p_first <= (k == '0);
          p_last  <= last_k;
          p_idx   <= IW'(32'(i)*N + 32'(j));
          if (last_k) begin
            k <= '0;
            if (last_j) begin
              j <= '0;
              if (last_i) begin
                i     <= '0;
                state <= S_FLUSH;
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            k <= k + CW'(LANES);
          end
        end
        S_FLUSH: state <= S_DONE;
        default: if (out_ready) state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_COMPUTE) || (state == S_FLUSH);
  assign C         = c_reg;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Randomized bench for mat_mult_seq against a plain-arithmetic matrix model,
// covering three parameter sets plus handshake, backpressure and reset cases.
module tb_mat_mult_seq;

  localparam int N = 4, BITS = 8, LANES = 2, W = N*N*BITS;
  localparam int N1 = 2, B1 = 4, L1 = 1, W1 = N1*N1*B1;
  localparam int N2 = 8, B2 = 16, L2 = 4, W2 = N2*N2*B2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, acc_en, out_valid, out_ready, busy;
  logic [W-1:0]  A, B, C;
  logic          u1_in_valid, u1_in_ready, u1_acc_en, u1_out_valid, u1_out_ready, u1_busy;
  logic [W1-1:0] u1_a, u1_b, u1_c;
  logic          u2_in_valid, u2_in_ready, u2_acc_en, u2_out_valid, u2_out_ready, u2_busy;
  logic [W2-1:0] u2_a, u2_b, u2_c;

  mat_mult_seq #(.BITS(BITS), .N(N), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .acc_en(acc_en),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .C(C), .busy(busy));

  mat_mult_seq #(.BITS(B1), .N(N1), .LANES(L1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(u1_in_valid), .in_ready(u1_in_ready), .acc_en(u1_acc_en),
    .A(u1_a), .B(u1_b), .out_valid(u1_out_valid), .out_ready(u1_out_ready), .C(u1_c), .busy(u1_busy));

  mat_mult_seq #(.BITS(B2), .N(N2), .LANES(L2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(u2_in_valid), .in_ready(u2_in_ready), .acc_en(u2_acc_en),
    .A(u2_a), .B(u2_b), .out_valid(u2_out_valid), .out_ready(u2_out_ready), .C(u2_c), .busy(u2_busy));

  int n_tests = 0;
  int n_fail  = 0;
  logic [1023:0] cprev0, cprev1, cprev2;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned el(input logic [1023:0] m, input int bits, input int idx);
    return 64'(m >> (bits*idx)) & ((64'(1) << bits) - 1);
  endfunction

  // C(r,c) = [C_prev(r,c)] + sum_k A(r,k)*B(k,c), each element reduced mod 2^bits.
  function automatic logic [1023:0] ref_mm(input int n, input int bits, input logic [1023:0] a,
                                           input logic [1023:0] b, input logic [1023:0] cp, input bit acc);
    logic [1023:0] r;
    longint unsigned s, m;
    r = '0;
    m = (64'(1) << bits) - 1;
    for (int rr = 0; rr < n; rr++)
      for (int cc = 0; cc < n; cc++) begin
        s = acc ? el(cp, bits, rr*n + cc) : 0;
        for (int kk = 0; kk < n; kk++) s += el(a, bits, rr*n + kk) * el(b, bits, kk*n + cc);
        r |= 1024'(s & m) << (bits*(rr*n + cc));
      end
    return r;
  endfunction

  function automatic logic [1023:0] rand_mat(input int n, input int bits);
    logic [1023:0] r;
    r = '0;
    for (int idx = 0; idx < n*n; idx++)
      r |= 1024'($urandom & ((32'(1) << bits) - 1)) << (bits*idx);
    return r;
  endfunction

  function automatic logic [1023:0] fill_mat(input int n, input int bits, input int diag, input int off);
    logic [1023:0] r;
    r = '0;
    for (int rr = 0; rr < n; rr++)
      for (int cc = 0; cc < n; cc++)
        r |= 1024'((rr == cc) ? diag : off) << (bits*(rr*n + cc));
    return r;
  endfunction

  task automatic run_main(input logic [W-1:0] a, input logic [W-1:0] b, input bit acc,
                          input int hold, output int lat);
    logic [1023:0] exp;
    int bad;
    @(negedge clk);
    check("main_in_ready_idle", 1024'(in_ready), 1024'(1));
    A = a; B = b; acc_en = acc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'(rand_mat(N, BITS)); B = W'(rand_mat(N, BITS));
    check("main_busy_compute", 1024'({busy, in_ready}), 1024'(2'b10));
    exp = ref_mm(N, BITS, 1024'(a), 1024'(b), cprev0, acc);
    cprev0 = exp;
    lat = 0;
    while (!out_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
    check("main_out_valid", 1024'(out_valid), 1024'(1));
    check("main_result", 1024'(C), exp);
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || 1024'(C) !== exp) bad++;
    end
    check("main_backpressure_hold", 1024'(bad), 1024'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("main_release", 1024'({out_valid, in_ready, busy}), 1024'(3'b010));
  endtask

  task automatic run_u1(input bit acc);
    logic [1023:0] a, b, exp;
    int t;
    a = rand_mat(N1, B1); b = rand_mat(N1, B1);
    @(negedge clk);
    u1_a = W1'(a); u1_b = W1'(b); u1_acc_en = acc; u1_in_valid = 1'b1;
    @(posedge clk); #1;
    u1_in_valid = 1'b0;
    exp = ref_mm(N1, B1, a, b, cprev1, acc);
    cprev1 = exp;
    t = 0;
    while (!u1_out_valid && t < 2000) begin @(posedge clk); #1; t++; end
    check("u1_latency", 1024'(t), 1024'(N1*N1*N1/L1 + 1));
    check("u1_result", 1024'(u1_c), exp);
    u1_out_ready = 1'b1;
    @(posedge clk); #1;
    u1_out_ready = 1'b0;
  endtask

  task automatic run_u2(input bit acc);
    logic [1023:0] a, b, exp;
    int t;
    a = rand_mat(N2, B2); b = rand_mat(N2, B2);
    @(negedge clk);
    u2_a = W2'(a); u2_b = W2'(b); u2_acc_en = acc; u2_in_valid = 1'b1;
    @(posedge clk); #1;
    u2_in_valid = 1'b0;
    exp = ref_mm(N2, B2, a, b, cprev2, acc);
    cprev2 = exp;
    t = 0;
    while (!u2_out_valid && t < 2000) begin @(posedge clk); #1; t++; end
    check("u2_latency", 1024'(t), 1024'(N2*N2*N2/L2 + 1));
    check("u2_result", 1024'(u2_c), exp);
    u2_out_ready = 1'b1;
    @(posedge clk); #1;
    u2_out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0; acc_en = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    u1_in_valid = 1'b0; u1_acc_en = 1'b0; u1_out_ready = 1'b0; u1_a = '0; u1_b = '0;
    u2_in_valid = 1'b0; u2_acc_en = 1'b0; u2_out_ready = 1'b0; u2_a = '0; u2_b = '0;
    cprev0 = '0; cprev1 = '0; cprev2 = '0;
    #23;
    check("reset_flags", 1024'({in_ready, out_valid, busy}), 1024'(3'b100));
    check("reset_c", 1024'(C), '0);
    @(negedge clk) rst_n = 1'b1;

    // Identity times B(r,c)=4r+c returns B, with the full fold latency.
    run_main(W'(fill_mat(N, BITS, 1, 0)), W'(ref_mm(N, BITS, '0, '0, '0, 0)) | W'(128'h0f0e0d0c0b0a09080706050403020100),
             1'b0, 0, lat);
    check("latency_identity", 1024'(lat), 1024'(N*N*N/LANES + 1));
    check("identity_is_b", 1024'(C), 1024'(128'h0f0e0d0c0b0a09080706050403020100));

    run_main(W'(fill_mat(N, BITS, 8'h10, 8'h10)), W'(fill_mat(N, BITS, 8'h10, 8'h10)), 1'b0, 0, lat);
    check("wrap_0x10", 1024'(C), '0);
    run_main(W'(fill_mat(N, BITS, 3, 3)), W'(fill_mat(N, BITS, 3, 3)), 1'b0, 0, lat);
    check("all_0x03", 1024'(C), fill_mat(N, BITS, 8'h24, 8'h24));

    run_main(W'(fill_mat(N, BITS, 1, 0)), W'(fill_mat(N, BITS, 1, 0)), 1'b0, 0, lat);
    run_main(W'(fill_mat(N, BITS, 1, 0)), W'(fill_mat(N, BITS, 1, 0)), 1'b1, 0, lat);
    check("accumulate_2i", 1024'(C), fill_mat(N, BITS, 2, 0));

    run_main(W'(rand_mat(N, BITS)), W'(rand_mat(N, BITS)), 1'b0, 20, lat);

    // Operand pulses during COMPUTE must be ignored.
    fork
      run_main(W'(rand_mat(N, BITS)), W'(rand_mat(N, BITS)), 1'b0, 0, lat);
      begin
        repeat (6) @(posedge clk);
        #2 A = W'(rand_mat(N, BITS)); B = W'(rand_mat(N, BITS)); acc_en = 1'b1; in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #2 in_valid = 1'b0; acc_en = 1'b0;
      end
    join

    // Abort mid-COMPUTE; the following accumulate starts from C_prev = 0.
    @(negedge clk);
    A = W'(rand_mat(N, BITS)); B = W'(rand_mat(N, BITS)); acc_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_flags", 1024'({in_ready, out_valid, busy}), 1024'(3'b100));
    check("abort_c", 1024'(C), '0);
    @(negedge clk) rst_n = 1'b1;
    cprev0 = '0; cprev1 = '0; cprev2 = '0;
    run_main(W'(rand_mat(N, BITS)), W'(rand_mat(N, BITS)), 1'b1, 0, lat);

    for (int r = 0; r < 12; r++) begin
      ra = W'(rand_mat(N, BITS));
      rb = W'(rand_mat(N, BITS));
      run_main(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), lat);
      check("random_latency", 1024'(lat), 1024'(N*N*N/LANES + 1));
    end
    for (int r = 0; r < 6; r++) run_u1(1'($urandom_range(0, 1)));
    for (int r = 0; r < 4; r++) run_u2(1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
